// File: rtl/param_stack.sv
// Parametrised operand stack: one push/pop/tos/dup/swap/replace/clear per clock,
// registered read data, occupancy flags and sticky overflow/underflow errors.
module param_stack #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_zero,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              unf
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_PUSH    = 3'b001;
    localparam logic [2:0] OP_POP     = 3'b010;
    localparam logic [2:0] OP_TOS     = 3'b011;
    localparam logic [2:0] OP_DUP     = 3'b100;
    localparam logic [2:0] OP_SWAP    = 3'b101;
    localparam logic [2:0] OP_REPLACE = 3'b110;
    localparam logic [2:0] OP_CLEAR   = 3'b111;

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [CNT_W-1:0]  count_r, count_nxt_s;
    logic [DATA_W-1:0] dout_r, dout_nxt_s;
    logic              valid_r, valid_nxt_s;
    logic              ovf_r, ovf_nxt_s;
    logic              unf_r, unf_nxt_s;

    logic              full_s, empty_s;
    logic [IDX_W-1:0]  top_idx_s, nxt_idx_s, wr_idx_s, we_idx_s;
    logic [DATA_W-1:0] t_s, n_s, we_data_s;
    logic              we_s, swap_s;

    // Index arithmetic is done at count width, then narrowed to the array index width.
    assign top_idx_s = IDX_W'(count_r - CNT_W'(1));
    assign nxt_idx_s = IDX_W'(count_r - CNT_W'(2));
    assign wr_idx_s  = IDX_W'(count_r);
    assign t_s       = mem_r[top_idx_s];
    assign n_s       = mem_r[nxt_idx_s];

    assign full_s     = (count_r == CNT_W'(DEPTH));
    assign empty_s    = (count_r == {CNT_W{1'b0}});
    assign full       = full_s;
    assign empty      = empty_s;
    assign count      = count_r;
    assign dout       = dout_r;
    assign dout_valid = valid_r;
    assign dout_zero  = (dout_r == {DATA_W{1'b0}});
    assign ovf        = ovf_r;
    assign unf        = unf_r;

    // Opcode decode: next control state and storage write requests.
    always_comb begin
        count_nxt_s = count_r;
        dout_nxt_s  = dout_r;
        valid_nxt_s = 1'b0;
        ovf_nxt_s   = ovf_r;
        unf_nxt_s   = unf_r;
        we_s        = 1'b0;
        we_idx_s    = wr_idx_s;
        we_data_s   = din;
        swap_s      = 1'b0;
        case (op)
            OP_NOP: begin
            end
            OP_PUSH: begin
                if (full_s) begin
                    ovf_nxt_s = 1'b1;
                end else begin
                    we_s        = 1'b1;
                    count_nxt_s = count_r + CNT_W'(1);
                end
            end
            OP_POP: begin
                if (empty_s) begin
                    unf_nxt_s = 1'b1;
                end else begin
                    dout_nxt_s  = t_s;
                    valid_nxt_s = 1'b1;
                    count_nxt_s = count_r - CNT_W'(1);
                end
            end
            OP_TOS: begin
                if (empty_s) begin
                    unf_nxt_s = 1'b1;
                end else begin
                    dout_nxt_s  = t_s;
                    valid_nxt_s = 1'b1;
                end
            end
            OP_DUP: begin
                // Empty is checked first; with DEPTH >= 2 the two errors are exclusive.
                if (empty_s) begin
                    unf_nxt_s = 1'b1;
                end else if (full_s) begin
                    ovf_nxt_s = 1'b1;
                end else begin
                    we_s        = 1'b1;
                    we_data_s   = t_s;
                    count_nxt_s = count_r + CNT_W'(1);
                end
            end
            OP_SWAP: begin
                if (count_r < CNT_W'(2)) begin
                    unf_nxt_s = 1'b1;
                end else begin
                    swap_s = 1'b1;
                end
            end
            OP_REPLACE: begin
                if (empty_s) begin
                    unf_nxt_s = 1'b1;
                end else begin
                    dout_nxt_s  = t_s;
                    valid_nxt_s = 1'b1;
                    we_s        = 1'b1;
                    we_idx_s    = top_idx_s;
                end
            end
            OP_CLEAR: begin
                count_nxt_s = {CNT_W{1'b0}};
                ovf_nxt_s   = 1'b0;
                unf_nxt_s   = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {CNT_W{1'b0}};
            dout_r  <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            dout_r  <= dout_nxt_s;
            valid_r <= valid_nxt_s;
            ovf_r   <= ovf_nxt_s;
            unf_r   <= unf_nxt_s;
        end
    end

    // Storage array; deliberately not reset since entries above count are don't-care.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[we_idx_s] <= we_data_s;
        end
        if (swap_s) begin
            mem_r[top_idx_s] <= n_s;
            mem_r[nxt_idx_s] <= t_s;
        end
    end

endmodule

// File: tb/tb_param_stack.sv
// Directed and randomised bench for param_stack with DATA_W = 8, DEPTH = 4.
module tb_param_stack;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int CW = $clog2(DP + 1);

    localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, TOS = 3'b011;
    localparam logic [2:0] DUP = 3'b100, SWAP = 3'b101, REPL = 3'b110, CLR = 3'b111;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    op;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          dout_valid, dout_zero, full, empty, ovf, unf;
    logic [CW-1:0] count;

    int errors = 0;
    int checks = 0;

    param_stack #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .op(op), .din(din),
        .dout(dout), .dout_valid(dout_valid), .dout_zero(dout_zero),
        .count(count), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [2:0] o, input logic [DW-1:0] d);
        op  = o;
        din = d;
        @(posedge clk);
        #1;
        op  = NOP;
        din = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        op  = NOP;
        din = 8'h00;
        #12;
        checks++;
        if ({dout, dout_valid, count, full, empty, ovf, unf, dout_zero} !==
            {8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got dout=%h v=%b cnt=%0d f=%b e=%b o=%b u=%b z=%b",
                     dout, dout_valid, count, full, empty, ovf, unf, dout_zero);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lifo();
        step(PUSH, 8'h11);
        step(PUSH, 8'h22);
        step(PUSH, 8'h33);
        checks++;
        if (count !== 3'd3) begin
            errors++; $display("FAIL lifo_count3: got %0d expected 3", count);
        end
        step(POP, 8'h00);
        checks++;
        if ({dout, dout_valid, count} !== {8'h33, 1'b1, 3'd2}) begin
            errors++; $display("FAIL lifo_pop1: got %h/%b/%0d expected 33/1/2", dout, dout_valid, count);
        end
        step(POP, 8'h00);
        checks++;
        if ({dout, dout_valid, count} !== {8'h22, 1'b1, 3'd1}) begin
            errors++; $display("FAIL lifo_pop2: got %h/%b/%0d expected 22/1/1", dout, dout_valid, count);
        end
        step(POP, 8'h00);
        checks++;
        if ({dout, dout_valid, count, empty, unf} !== {8'h11, 1'b1, 3'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL lifo_pop3: got %h/%b/%0d e=%b u=%b expected 11/1/0 e=1 u=0",
                               dout, dout_valid, count, empty, unf);
        end
        step(NOP, 8'h00);
        checks++;
        if ({dout, dout_valid} !== {8'h11, 1'b0}) begin
            errors++; $display("FAIL lifo_nop: got %h/%b expected 11/0", dout, dout_valid);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) begin
            step(PUSH, 8'(i));
        end
        checks++;
        if ({full, count, ovf} !== {1'b1, 3'd4, 1'b0}) begin
            errors++; $display("FAIL ovf_full: got f=%b cnt=%0d o=%b expected 1/4/0", full, count, ovf);
        end
        step(PUSH, 8'h05);
        checks++;
        if ({ovf, count, full} !== {1'b1, 3'd4, 1'b1}) begin
            errors++; $display("FAIL ovf_set: got o=%b cnt=%0d f=%b expected 1/4/1", ovf, count, full);
        end
        step(POP, 8'h00);
        checks++;
        if ({dout, dout_valid, count, ovf} !== {8'h04, 1'b1, 3'd3, 1'b1}) begin
            errors++; $display("FAIL ovf_pop: got %h/%b/%0d o=%b expected 04/1/3 o=1", dout, dout_valid, count, ovf);
        end
        step(CLR, 8'h00);
        checks++;
        if ({count, ovf, unf, dout_valid, dout} !== {3'd0, 1'b0, 1'b0, 1'b0, 8'h04}) begin
            errors++; $display("FAIL ovf_clear: got cnt=%0d o=%b u=%b v=%b dout=%h expected 0/0/0/0/04",
                               count, ovf, unf, dout_valid, dout);
        end
    endtask

    task automatic test_underflow();
        int pulses = 0;
        step(POP, 8'h00);   pulses += int'(dout_valid);
        step(TOS, 8'h00);   pulses += int'(dout_valid);
        step(SWAP, 8'h00);  pulses += int'(dout_valid);
        step(REPL, 8'h07);  pulses += int'(dout_valid);
        checks++;
        if ({unf, count, dout, ovf} !== {1'b1, 3'd0, 8'h04, 1'b0} || pulses != 0) begin
            errors++; $display("FAIL unf_empty: got u=%b cnt=%0d dout=%h o=%b pulses=%0d expected 1/0/04/0/0",
                               unf, count, dout, ovf, pulses);
        end
        step(PUSH, 8'h09);
        step(SWAP, 8'h00);
        step(TOS, 8'h00);
        checks++;
        if ({unf, count, dout, dout_valid} !== {1'b1, 3'd1, 8'h09, 1'b1}) begin
            errors++; $display("FAIL unf_swap1: got u=%b cnt=%0d dout=%h v=%b expected 1/1/09/1",
                               unf, count, dout, dout_valid);
        end
        step(CLR, 8'h00);
    endtask

    task automatic test_dup_swap_replace();
        step(PUSH, 8'h0A);
        step(PUSH, 8'h0B);
        step(SWAP, 8'h00);
        step(TOS, 8'h00);
        checks++;
        if ({dout, dout_valid, unf} !== {8'h0A, 1'b1, 1'b0}) begin
            errors++; $display("FAIL dsr_swap_tos: got %h/%b u=%b expected 0A/1 u=0", dout, dout_valid, unf);
        end
        step(DUP, 8'h00);
        checks++;
        if ({count, dout_valid} !== {3'd3, 1'b0}) begin
            errors++; $display("FAIL dsr_dup: got cnt=%0d v=%b expected 3/0", count, dout_valid);
        end
        step(REPL, 8'h00);
        checks++;
        if ({dout, dout_valid, dout_zero, count} !== {8'h0A, 1'b1, 1'b0, 3'd3}) begin
            errors++; $display("FAIL dsr_replace: got %h/%b z=%b cnt=%0d expected 0A/1 z=0 cnt=3",
                               dout, dout_valid, dout_zero, count);
        end
        step(TOS, 8'h00);
        checks++;
        if ({dout, dout_zero} !== {8'h00, 1'b1}) begin
            errors++; $display("FAIL dsr_tos_zero: got %h z=%b expected 00 z=1", dout, dout_zero);
        end
        step(PUSH, 8'h0C);
        step(DUP, 8'h00);
        checks++;
        if ({ovf, count, unf} !== {1'b1, 3'd4, 1'b0}) begin
            errors++; $display("FAIL dsr_dup_full: got o=%b cnt=%0d u=%b expected 1/4/0", ovf, count, unf);
        end
        step(POP, 8'h00);
        step(POP, 8'h00);
        step(POP, 8'h00);
        checks++;
        if ({dout, count} !== {8'h0A, 3'd1}) begin
            errors++; $display("FAIL dsr_contents: got %h cnt=%0d expected 0A cnt=1", dout, count);
        end
        step(POP, 8'h00);
        checks++;
        if ({dout, count, empty} !== {8'h0B, 3'd0, 1'b1}) begin
            errors++; $display("FAIL dsr_bottom: got %h cnt=%0d e=%b expected 0B/0/1", dout, count, empty);
        end
        step(CLR, 8'h00);
    endtask

    task automatic test_reset_mid();
        step(PUSH, 8'h01);
        step(PUSH, 8'h02);
        step(PUSH, 8'h03);
        step(PUSH, 8'h04);
        step(PUSH, 8'h05);
        step(POP, 8'h00);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({count, dout, dout_valid, ovf, unf, empty, full, dout_zero} !==
            {3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            errors++; $display("FAIL mid_reset: got cnt=%0d dout=%h v=%b o=%b u=%b e=%b f=%b z=%b",
                               count, dout, dout_valid, ovf, unf, empty, full, dout_zero);
        end
        op  = PUSH;
        din = 8'hFF;
        @(posedge clk);
        #1;
        checks++;
        if (count !== 3'd0) begin
            errors++; $display("FAIL mid_reset_hold: got cnt=%0d expected 0", count);
        end
        op = NOP;
        @(negedge clk);
        rst = 1'b1;
        step(PUSH, 8'h5A);
        step(POP, 8'h00);
        checks++;
        if ({dout, dout_valid, count} !== {8'h5A, 1'b1, 3'd0}) begin
            errors++; $display("FAIL mid_reset_after: got %h/%b/%0d expected 5A/1/0", dout, dout_valid, count);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] q[$];
        logic [DW-1:0] m_dout = 8'h5A;
        logic          m_valid, m_ovf = 1'b0, m_unf = 1'b0;
        logic [2:0]    o;
        logic [DW-1:0] d;
        int            r;
        for (int i = 0; i < 1000; i++) begin
            r = $urandom_range(0, 19);
            o = (r < 10) ? PUSH : ((r < 19) ? POP : CLR);
            d = 8'($urandom);
            m_valid = 1'b0;
            if (o == PUSH) begin
                if (q.size() == DP) m_ovf = 1'b1;
                else q.push_back(d);
            end else if (o == POP) begin
                if (q.size() == 0) m_unf = 1'b1;
                else begin
                    m_dout  = q.pop_back();
                    m_valid = 1'b1;
                end
            end else begin
                q.delete();
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            step(o, d);
            checks++;
            if ({dout, dout_valid, count, full, empty, ovf, unf} !==
                {m_dout, m_valid, CW'(q.size()), q.size() == DP, q.size() == 0, m_ovf, m_unf}) begin
                errors++;
                $display("FAIL b2b cycle %0d op=%0d: got dout=%h v=%b cnt=%0d f=%b e=%b o=%b u=%b expected dout=%h v=%b cnt=%0d o=%b u=%b",
                         i, o, dout, dout_valid, count, full, empty, ovf, unf,
                         m_dout, m_valid, q.size(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_overflow();
        test_underflow();
        test_dup_swap_replace();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_stack.md
# param_stack

Parametrised hardware operand stack for the multicycle stack CPU, replacing the fixed-size stack that feeds the A/B operand registers and the zero flag. It executes one stack operation per clock from an encoded opcode: push, pop, top-read, dup, swap, replace and clear. It returns popped or read values through a registered output and reports occupancy, full/empty and sticky overflow/underflow errors to the controller.

## Interface
- DATA_W, 8, word width; DATA_W ≥ 1.
- DEPTH, 32, number of entries; DEPTH ≥ 2, any integer (not restricted to powers of two).
- CNT_W, $clog2(DEPTH+1), derived width of count; not overridden.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- op  in  3  operation: 000 NOP, 001 PUSH, 010 POP, 011 TOS, 100 DUP, 101 SWAP, 110 REPLACE, 111 CLEAR.
- din  in  DATA_W  operand for PUSH and REPLACE.
- dout  out  DATA_W  registered read data.
- dout_valid  out  1  one-cycle pulse: dout updated by this op.
- dout_zero  out  1  combinational, dout == 0 (feeds branch condition).
- count  out  CNT_W  current number of entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- ovf  out  1  sticky overflow error.
- unf  out  1  sticky underflow error.

## Operation
- The storage array holds entries 0..count-1; entry count-1 is the top (T), and entry count-2 is next-of-top (N).
- PUSH: if not full, store din at index count and increment count. If full, leave storage and count unchanged and set ovf.
- POP: if not empty, dout ← T, pulse dout_valid and decrement count. If empty, set unf; dout and count are unchanged.
- TOS: if not empty, dout ← T and pulse dout_valid; count is unchanged. If empty, set unf.
- DUP: requires count ≥ 1 and not full. On success, copy T to index count and increment count. If empty, set unf. Otherwise, if full, set ovf. Both errors cannot be set by the same DUP, because DEPTH ≥ 2.
- SWAP: requires count ≥ 2; on success, exchange T and N. If count < 2, set unf and change nothing.
- REPLACE: if not empty, dout ← old T, T ← din and pulse dout_valid; count is unchanged. If empty, set unf and do not write.
- CLEAR: count ← 0, ovf ← 0 and unf ← 0. dout holds its value, and dout_valid is 0.
- NOP: no state change.
- Errors are sticky until CLEAR or reset. A failed op changes no other state.
- The storage array is not reset. Entries at index count and above are don't-care and never appear on dout.
- dout_valid is 0 on every cycle except the one following a successful POP, TOS or REPLACE.

## Timing
- op and din are sampled on the rising edge of clk. All effects, including dout and dout_valid, are visible after that edge, so read latency is 1 cycle.
- One op is accepted per cycle with no stall. Back-to-back ops see the results of the previous op, e.g. PUSH then POP returns the pushed value.
- full, empty and count reflect the registered state; full and empty are decoded combinationally from count.
- Asserting rst (low), at any time including mid-sequence, immediately sets:
  - dout = 0, dout_valid = 0, count = 0, ovf = 0, unf = 0;
  - hence empty = 1, full = 0 and dout_zero = 1.
- The op on the edge that coincides with reset assertion is discarded.
- The first op after rst deasserts executes on the first rising edge at which rst is high.
- Boundaries:
  - PUSH at count = DEPTH-1 reaches full, and the next PUSH sets ovf.
  - POP at count = 1 reaches empty.
  - count never wraps below 0 or above DEPTH.

## Test plan
All scenarios use DATA_W = 8, DEPTH = 4.
- Reset then LIFO: after reset, PUSH 0x11, 0x22, 0x33, then POP ×3 → dout 0x33, 0x22, 0x11 on successive cycles with dout_valid high each time; count 3→0; empty = 1; unf = 0.
- Overflow: PUSH 0x01–0x04 → full = 1, count = 4. A PUSH of 0x05 → ovf = 1 with count still 4. POP → 0x04. CLEAR → count = 0, ovf = 0.
- Underflow: POP, TOS, SWAP and REPLACE 0x7 on an empty stack → unf = 1, dout_valid never pulses, count = 0. PUSH 0x09 then SWAP → unf stays 1 and T remains 0x09.
- DUP/SWAP/REPLACE:
  - PUSH 0x0A, PUSH 0x0B, SWAP, then TOS → 0x0A.
  - DUP → count = 3.
  - REPLACE 0x00 → dout = 0x0A, dout_zero = 0; a following TOS gives dout = 0x00 and dout_zero = 1.
  - DUP at count = 4 → ovf = 1.
- Reset mid-operation: PUSH ×3, then assert rst asynchronously between edges → count = 0, dout = 0 and flags cleared immediately without waiting for a clock edge. After release, PUSH 0x5A then POP → 0x5A.
- Back-to-back PUSH/POP alternation for 1000 random cycles against a reference model → dout, count, full, empty, ovf and unf match every cycle.
